// File: rtl/lif_pkg.sv
// Shared types and constants for the time-multiplexed LIF neuron scheduler.
package lif_pkg;

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] SAT_MAX = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_STALL
  } lif_state_e;

endpackage

// File: rtl/lif_update.sv
// Combinational LIF datapath: leak by shift, integrate current, saturate, compare.
module lif_update
  import lif_pkg::*;
(
  input  logic [DATA_W-1:0] state_i,
  input  logic [DATA_W-1:0] current_i,
  input  logic [DATA_W-1:0] thresh_i,
  input  logic [2:0]        leak_shift_i,
  output logic [DATA_W-1:0] next_o,
  output logic              fire_o
);

  logic [DATA_W-1:0] leaked;
  logic [DATA_W:0]   sum;

  // state - (state >> k) never underflows, so only the add needs the carry bit
  assign leaked = state_i - (state_i >> leak_shift_i);
  assign sum    = {1'b0, leaked} + {1'b0, current_i};
  assign next_o = sum[DATA_W] ? SAT_MAX : sum[DATA_W-1:0];
  assign fire_o = (next_o >= thresh_i);

endmodule

// File: rtl/lif_scheduler.sv
// Round-robin scheduler sharing one LIF update datapath across N virtual neurons,
// with a single-entry spike output buffer that back-pressures the update loop.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int REFRAC    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic [DATA_W-1:0]            cur_in,
  input  logic [$clog2(N_NEURONS)-1:0] cur_sel,
  input  logic                         cur_we,
  input  logic [DATA_W-1:0]            thresh,
  input  logic [2:0]                   leak_shift,
  output logic [DATA_W-1:0]            state_out,
  output logic                         spike_valid,
  output logic [$clog2(N_NEURONS)-1:0] spike_id,
  input  logic                         spike_ready,
  output logic                         busy
);

  localparam int IW = $clog2(N_NEURONS);
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [RW-1:0] REFRAC_V = RW'(REFRAC);

  lif_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [DATA_W-1:0] mem_state_q [N_NEURONS];
  logic [DATA_W-1:0] mem_cur_q   [N_NEURONS];
  logic [RW-1:0]     mem_ref_q   [N_NEURONS];

  logic [DATA_W-1:0] op_state_q, op_cur_q, op_thresh_q;
  logic [2:0]        op_shift_q;
  logic [RW-1:0]     op_ref_q;

  logic [DATA_W-1:0] state_out_q;
  logic              spk_valid_q;
  logic [IW-1:0]     spk_id_q;

  logic [DATA_W-1:0] upd_next;
  logic              upd_fire;
  logic              handshake, commit, load_evt;
  logic [DATA_W-1:0] wb_state;
  logic [RW-1:0]     wb_ref;

  lif_update u_update (
    .state_i     (op_state_q),
    .current_i   (op_cur_q),
    .thresh_i    (op_thresh_q),
    .leak_shift_i(op_shift_q),
    .next_o      (upd_next),
    .fire_o      (upd_fire)
  );

  assign handshake = spk_valid_q & spike_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    commit   = 1'b0;
    load_evt = 1'b0;
    wb_state = '0;
    wb_ref   = '0;
    case (state_q)
      ST_IDLE:  if (ena) state_d = ST_READ;
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: begin
        if (op_ref_q != '0) begin
          commit = 1'b1;
          wb_ref = op_ref_q - RW'(1);
        end else if (upd_fire) begin
          // A spike may only retire once the buffer has room (or frees up this cycle)
          if (!spk_valid_q || handshake) begin
            commit   = 1'b1;
            load_evt = 1'b1;
            wb_ref   = REFRAC_V;
          end else begin
            state_d = ST_STALL;
          end
        end else begin
          commit   = 1'b1;
          wb_state = upd_next;
        end
      end
      ST_STALL: begin
        if (handshake) begin
          commit   = 1'b1;
          load_evt = 1'b1;
          wb_ref   = REFRAC_V;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
    if (commit) begin
      idx_d   = (idx_q == IW'(N_NEURONS - 1)) ? '0 : idx_q + IW'(1);
      state_d = ena ? ST_READ : ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      op_state_q  <= '0;
      op_cur_q    <= '0;
      op_thresh_q <= '0;
      op_shift_q  <= '0;
      op_ref_q    <= '0;
      state_out_q <= '0;
      spk_valid_q <= 1'b0;
      spk_id_q    <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        mem_state_q[i] <= '0;
        mem_cur_q[i]   <= '0;
        mem_ref_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == ST_READ) begin
        op_state_q  <= mem_state_q[idx_q];
        op_cur_q    <= mem_cur_q[idx_q];
        op_ref_q    <= mem_ref_q[idx_q];
        op_thresh_q <= thresh;
        op_shift_q  <= leak_shift;
      end
      // Same-edge write to the neuron being read lands after the operand capture
      if (cur_we) mem_cur_q[cur_sel] <= cur_in;
      if (commit) begin
        mem_state_q[idx_q] <= wb_state;
        mem_ref_q[idx_q]   <= wb_ref;
        state_out_q        <= wb_state;
      end
      if (load_evt) begin
        spk_valid_q <= 1'b1;
        spk_id_q    <= idx_q;
      end else if (handshake) begin
        spk_valid_q <= 1'b0;
      end
    end
  end

  assign state_out   = state_out_q;
  assign spike_valid = spk_valid_q;
  assign spike_id    = spk_id_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lif_scheduler.sv
// Directed and randomized checks of lif_scheduler against a per-update LIF reference model.
module tb_lif_scheduler;

  localparam int N  = 4;
  localparam int R  = 2;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [7:0]    cur_in = '0;
  logic [IW-1:0] cur_sel = '0;
  logic          cur_we = 1'b0;
  logic [7:0]    thresh = '0;
  logic [2:0]    leak_shift = '0;
  logic [7:0]    state_out;
  logic          spike_valid;
  logic [IW-1:0] spike_id;
  logic          spike_ready = 1'b1;
  logic          busy;

  int checks = 0;
  int errors = 0;

  int m_state [N];
  int m_cur   [N];
  int m_ref   [N];
  int m_idx;
  int evq [$];
  logic [8:0] n1_obs [$];

  lif_scheduler #(.N_NEURONS(N), .REFRAC(R)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .cur_in     (cur_in),
    .cur_sel    (cur_sel),
    .cur_we     (cur_we),
    .thresh     (thresh),
    .leak_shift (leak_shift),
    .state_out  (state_out),
    .spike_valid(spike_valid),
    .spike_id   (spike_id),
    .spike_ready(spike_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Record every delivered event in delivery order
  always @(posedge clk) begin
    if (rst_n && spike_valid && spike_ready) evq.push_back(int'(spike_id));
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0;
      m_cur[i]   = 0;
      m_ref[i]   = 0;
    end
    m_idx = 0;
    evq.delete();
  endtask

  // One neuron update as described by the LIF rules, on plain integers
  task automatic model_step(input int thr, input int ls, output int es, output bit espk, output int eid);
    int i;
    int v;
    i = m_idx;
    espk = 1'b0;
    if (m_ref[i] > 0) begin
      m_state[i] = 0;
      m_ref[i] = m_ref[i] - 1;
    end else begin
      v = m_state[i] - (m_state[i] / (1 << ls)) + m_cur[i];
      if (v > 255) v = 255;
      if (v >= thr) begin
        espk = 1'b1;
        m_state[i] = 0;
        m_ref[i] = R;
      end else begin
        m_state[i] = v;
      end
    end
    es  = m_state[i];
    eid = i;
    m_idx = (m_idx + 1) % N;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena = 1'b0;
    cur_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    chk("rst_state_out", 32'(state_out), 0);
    chk("rst_spike_valid", 32'(spike_valid), 0);
    chk("rst_spike_id", 32'(spike_id), 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  task automatic write_cur(input int sel, input int val);
    cur_we = 1'b1;
    cur_sel = IW'(sel);
    cur_in = 8'(val);
    @(posedge clk);
    @(negedge clk);
    cur_we = 1'b0;
    m_cur[sel] = val;
  endtask

  // Leaves the bench at the negedge with the DUT in READ
  task automatic start();
    ena = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete update (READ edge + WRITE edge), assuming the buffer never blocks
  task automatic upd(input int thr, input int ls, input bit we, input int sel, input int val,
                     input bit stop, input string tag);
    int es;
    int eid;
    bit espk;
    thresh = 8'(thr);
    leak_shift = 3'(ls);
    if (we) begin
      cur_we = 1'b1;
      cur_sel = IW'(sel);
      cur_in = 8'(val);
    end
    if (stop) ena = 1'b0;
    model_step(thr, ls, es, espk, eid);
    if (we) m_cur[sel] = val;
    @(posedge clk);
    #1 cur_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    $display("update %s: neuron %0d state_out=%0d spike_valid=%0d spike_id=%0d",
             tag, eid, state_out, spike_valid, spike_id);
    chk({tag, "_state"}, 32'(state_out), 32'(es));
    chk({tag, "_valid"}, 32'(spike_valid), 32'(espk));
    if (espk) chk({tag, "_id"}, 32'(spike_id), 32'(eid));
    chk({tag, "_busy"}, 32'(busy), 32'(!stop));
  endtask

  initial begin
    logic [8:0] exp_n1 [7];
    exp_n1 = '{9'h028, 9'h050, 9'h100, 9'h000, 9'h000, 9'h028, 9'h050};

    // Idle loop with all currents zero
    do_reset();
    spike_ready = 1'b1;
    start();
    chk("run_busy", 32'(busy), 1);
    for (int k = 0; k < 8; k++) upd(100, 3, 1'b0, 0, 0, k == 7, "zero");

    // Integrate to threshold, refractory, resume
    do_reset();
    write_cur(1, 40);
    start();
    n1_obs.delete();
    for (int k = 0; k < 28; k++) begin
      upd(100, 7, 1'b0, 0, 0, k == 27, "integ");
      if (k % 4 == 1) n1_obs.push_back({spike_valid, state_out});
    end
    for (int v = 0; v < 7; v++) chk("n1_visit", 32'(n1_obs[v]), 32'(exp_n1[v]));

    // Saturation to 255 fires at thresh 255
    do_reset();
    write_cur(0, 200);
    start();
    upd(255, 1, 1'b0, 0, 0, 1'b0, "sat0");
    chk("sat_first", 32'(state_out), 200);
    for (int k = 0; k < 3; k++) upd(255, 1, 1'b0, 0, 0, 1'b0, "sat_other");
    upd(255, 1, 1'b0, 0, 0, 1'b1, "sat1");
    chk("sat_spike", 32'(spike_valid), 1);
    chk("sat_spike_id", 32'(spike_id), 0);

    // Current write coinciding with READ of the same neuron
    do_reset();
    write_cur(2, 10);
    start();
    upd(255, 7, 1'b0, 0, 0, 1'b0, "cw_n0");
    upd(255, 7, 1'b0, 0, 0, 1'b0, "cw_n1");
    upd(255, 7, 1'b1, 2, 30, 1'b0, "cw_n2a");
    chk("cw_old_current", 32'(state_out), 10);
    upd(255, 7, 1'b0, 0, 0, 1'b0, "cw_n3");
    upd(255, 7, 1'b0, 0, 0, 1'b0, "cw_n0b");
    upd(255, 7, 1'b0, 0, 0, 1'b0, "cw_n1b");
    upd(255, 7, 1'b0, 0, 0, 1'b1, "cw_n2b");
    chk("cw_new_current", 32'(state_out), 40);

    // Back-pressure: second spike stalls until the consumer drains the first
    do_reset();
    spike_ready = 1'b0;
    thresh = 8'd0;
    leak_shift = 3'd0;
    start();
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("stall_first_valid", 32'(spike_valid), 1);
    chk("stall_first_id", 32'(spike_id), 0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    repeat (3) @(negedge clk);
    chk("stall_busy", 32'(busy), 1);
    chk("stall_hold_id", 32'(spike_id), 0);
    chk("stall_hold_valid", 32'(spike_valid), 1);
    spike_ready = 1'b1;
    ena = 1'b0;
    @(negedge clk);
    chk("stall_release_id", 32'(spike_id), 1);
    chk("stall_release_valid", 32'(spike_valid), 1);
    chk("stall_release_idle", 32'(busy), 0);
    @(negedge clk);
    chk("stall_drained", 32'(spike_valid), 0);
    chk("stall_event_count", 32'(evq.size()), 2);
    if (evq.size() == 2) begin
      chk("stall_event0", 32'(evq[0]), 0);
      chk("stall_event1", 32'(evq[1]), 1);
    end
    $display("stall test: %0d events delivered", evq.size());

    // Reset asserted while stalled discards the pending update and event
    do_reset();
    write_cur(0, 50);
    spike_ready = 1'b1;
    start();
    upd(255, 7, 1'b0, 0, 0, 1'b0, "rs_n0");
    spike_ready = 1'b0;
    upd(0, 7, 1'b0, 0, 0, 1'b0, "rs_n1");
    thresh = 8'd0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rs_stalled_busy", 32'(busy), 1);
    chk("rs_stalled_id", 32'(spike_id), 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rs_state_out", 32'(state_out), 0);
    chk("rs_valid", 32'(spike_valid), 0);
    chk("rs_id", 32'(spike_id), 0);
    chk("rs_busy", 32'(busy), 0);
    rst_n = 1'b1;
    model_clear();
    spike_ready = 1'b1;
    start();
    upd(255, 7, 1'b0, 0, 0, 1'b1, "rs_after");

    // Randomized updates against the reference model
    do_reset();
    spike_ready = 1'b1;
    start();
    for (int k = 0; k < 60; k++) begin
      int thr;
      int ls;
      bit we;
      thr = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(20, 255));
      ls  = int'($urandom_range(0, 7));
      we  = ($urandom_range(0, 9) < 3);
      upd(thr, ls, we, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 90)),
          k == 59, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
